risc16_mc_control: RTL and testbench

Multi-cycle control unit for the RiSC-16 core. It is the successor to the single-cycle decoder and keeps the same datapath select encodings. A state machine sequences each instruction through fetch, decode, execute and memory phases, with req/ack handshakes to instruction and data memory. It adds a configurable memory timeout, halt detection, run/stop control and a retired-instruction counter. It sits between the instruction register / register-file datapath and the memory ports.

---
 rtl/risc16_mc_control.sv | 226 ++++++++++++++++++++++
 tb/tb_risc16_mc_control.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/risc16_mc_control.sv
// risc16_mc_control: multi-cycle control unit for the RiSC-16 core.
// Sequences each instruction through FETCH / DECODE / EXEC / MEM using
// req/ack handshakes to instruction and data memory. The datapath select
// encodings match the single-cycle decoder. Adds a memory timeout,
// sticky halt/error flags, run/stop control and a retired-instruction
// counter.
module risc16_mc_control #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [2:0]       op,
    input  logic             EQ,
    input  logic             halt_hint,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             WE_ir,
    output logic             WE_pc,
    output logic [1:0]       FUNC_alu,
    output logic             MUX_alu1,
    output logic             MUX_alu2,
    output logic             MUX_rf,
    output logic [1:0]       MUX_pc,
    output logic [1:0]       MUX_tgt,
    output logic             WE_rf,
    output logic             WE_dmem,
    output logic             halted,
    output logic             err_timeout,
    output logic [CNT_W-1:0] instr_count,
    output logic [2:0]       state
);

    // Opcodes
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_LUI  = 3'b011;
    localparam logic [2:0] OP_LW   = 3'b100;
    localparam logic [2:0] OP_SW   = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_JALR = 3'b111;

    // ALU functions
    localparam logic [1:0] F_ADD  = 2'b00;
    localparam logic [1:0] F_NAND = 2'b01;
    localparam logic [1:0] F_PASS = 2'b10;
    localparam logic [1:0] F_EQL  = 2'b11;

    // PC / register-write target selects
    localparam logic [1:0] PC_INC  = 2'b00;
    localparam logic [1:0] PC_BR   = 2'b01;
    localparam logic [1:0] PC_JALR = 2'b10;
    localparam logic [1:0] TGT_MEM = 2'b00;
    localparam logic [1:0] TGT_ALU = 2'b01;
    localparam logic [1:0] TGT_PC1 = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_FETCH  = 3'b001,
        S_DECODE = 3'b010,
        S_EXEC   = 3'b011,
        S_MEM    = 3'b100,
        S_HALT   = 3'b101,
        S_ERROR  = 3'b110
    } state_e;

    // The wait counter only needs to hold 0..TIMEOUT-1: the cycle that
    // would take it to TIMEOUT is the cycle that decides ERROR instead.
    localparam int unsigned TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam bit TMO_EN = (TIMEOUT != 0);

    state_e             state_q, state_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               halted_q, halted_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tmo_hit;

    // Per-opcode ALU selects, shared by EXEC and MEM so MEM holds them.
    logic [1:0]         sel_func;
    logic               sel_alu1, sel_alu2, sel_rf;
    logic [1:0]         sel_pc, sel_tgt;

    assign tmo_hit = TMO_EN && (tmo_q == TMO_LAST);

    // Decode opcode into the datapath selects used during EXEC/MEM.
    always_comb begin
        sel_func = F_ADD;
        sel_alu1 = 1'b0;
        sel_alu2 = 1'b0;
        sel_rf   = 1'b0;
        sel_pc   = PC_INC;
        sel_tgt  = TGT_ALU;
        case (op)
            OP_ADD:  sel_func = F_ADD;
            OP_ADDI: begin sel_func = F_ADD; sel_alu2 = 1'b1; end
            OP_NAND: sel_func = F_NAND;
            OP_LUI:  begin sel_func = F_PASS; sel_alu1 = 1'b1; end
            OP_LW:   begin sel_func = F_ADD; sel_alu2 = 1'b1; end
            OP_SW:   begin sel_func = F_ADD; sel_alu2 = 1'b1; sel_rf = 1'b1; end
            OP_BEQ:  begin sel_func = F_EQL; sel_rf = 1'b1; end
            OP_JALR: begin sel_func = F_PASS; sel_tgt = TGT_PC1; sel_pc = PC_JALR; end
            default: sel_func = F_ADD;
        endcase
    end

    // Next-state, wait counter and all control outputs.
    always_comb begin
        state_d  = state_q;
        tmo_d    = '0;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        WE_ir    = 1'b0;
        WE_pc    = 1'b0;
        WE_rf    = 1'b0;
        WE_dmem  = 1'b0;
        FUNC_alu = F_ADD;
        MUX_alu1 = 1'b0;
        MUX_alu2 = 1'b0;
        MUX_rf   = 1'b0;
        MUX_pc   = PC_INC;
        MUX_tgt  = TGT_ALU;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    WE_ir   = 1'b1;
                    state_d = S_DECODE;
                end else if (tmo_hit) begin
                    state_d = S_ERROR;
                end else if (TMO_EN) begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_DECODE: begin
                if (op == OP_JALR && halt_hint) state_d = S_HALT;
                else                            state_d = S_EXEC;
            end
            S_EXEC: begin
                FUNC_alu = sel_func;
                MUX_alu1 = sel_alu1;
                MUX_alu2 = sel_alu2;
                MUX_rf   = sel_rf;
                MUX_pc   = sel_pc;
                MUX_tgt  = sel_tgt;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEM;
                    OP_BEQ: begin
                        WE_pc   = 1'b1;
                        MUX_pc  = EQ ? PC_BR : PC_INC;
                        state_d = run ? S_FETCH : S_IDLE;
                    end
                    default: begin
                        WE_rf   = 1'b1;
                        WE_pc   = 1'b1;
                        state_d = run ? S_FETCH : S_IDLE;
                    end
                endcase
            end
            S_MEM: begin
                FUNC_alu = sel_func;
                MUX_alu1 = sel_alu1;
                MUX_alu2 = sel_alu2;
                MUX_rf   = sel_rf;
                MUX_pc   = sel_pc;
                MUX_tgt  = sel_tgt;
                dmem_req = 1'b1;
                // SW keeps the write strobe up for the whole access.
                if (op == OP_SW) WE_dmem = 1'b1;
                if (dmem_ack) begin
                    if (op == OP_LW) begin
                        WE_rf   = 1'b1;
                        MUX_tgt = TGT_MEM;
                    end
                    WE_pc   = 1'b1;
                    state_d = run ? S_FETCH : S_IDLE;
                end else if (tmo_hit) begin
                    state_d = S_ERROR;
                end else if (TMO_EN) begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_HALT:  state_d = S_HALT;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
        endcase
    end

    // Sticky flags and retire counter next-state.
    always_comb begin
        halted_d = halted_q | (state_d == S_HALT);
        err_d    = err_q | (state_d == S_ERROR);
        cnt_d    = WE_pc ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // State, wait counter, flags and counter registers; synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            tmo_q    <= '0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            tmo_q    <= tmo_d;
            halted_q <= halted_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign state       = state_q;
    assign halted      = halted_q;
    assign err_timeout = err_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_risc16_mc_control.sv
// Self-checking bench for risc16_mc_control (TIMEOUT=4, CNT_W=4).
// Expected per-instruction results are queued when an instruction is
// issued and popped when the DUT retires it.
module tb_risc16_mc_control;

    localparam logic [2:0] OP_ADD = 3'd0, OP_ADDI = 3'd1, OP_NAND = 3'd2, OP_LUI = 3'd3;
    localparam logic [2:0] OP_LW  = 3'd4, OP_SW   = 3'd5, OP_BEQ  = 3'd6, OP_JALR = 3'd7;
    localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2, ST_EXEC = 3'd3;
    localparam logic [2:0] ST_MEM  = 3'd4, ST_HALT  = 3'd5, ST_ERROR  = 3'd6;

    logic       clk = 1'b0;
    logic       rst_n, run, EQ, halt_hint, imem_ack, dmem_ack;
    logic [2:0] op;
    logic       imem_req, dmem_req, WE_ir, WE_pc, MUX_alu1, MUX_alu2, MUX_rf, WE_rf, WE_dmem;
    logic       halted, err_timeout;
    logic [1:0] FUNC_alu, MUX_pc, MUX_tgt;
    logic [3:0] instr_count;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    typedef struct {
        int         cycles;
        logic       rf;
        logic [1:0] func, tgt, pc;
        logic       a1, a2, mrf;
        int         rf_n, dq_n, wd_n;
        logic [3:0] cnt;
    } exp_t;
    exp_t sb[$];

    int         a_fetch, a_mem;
    logic [2:0] a_end;

    risc16_mc_control #(.TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .op(op), .EQ(EQ), .halt_hint(halt_hint),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .dmem_req(dmem_req),
        .WE_ir(WE_ir), .WE_pc(WE_pc), .FUNC_alu(FUNC_alu), .MUX_alu1(MUX_alu1),
        .MUX_alu2(MUX_alu2), .MUX_rf(MUX_rf), .MUX_pc(MUX_pc), .MUX_tgt(MUX_tgt),
        .WE_rf(WE_rf), .WE_dmem(WE_dmem), .halted(halted), .err_timeout(err_timeout),
        .instr_count(instr_count), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Reference behaviour of one retiring instruction.
    function automatic exp_t model(input logic [2:0] o, input logic e, input int iw, input int dw);
        exp_t x;
        bit mem;
        mem      = (o == OP_LW) || (o == OP_SW);
        x.cycles = 3 + iw + (mem ? 1 + dw : 0);
        x.rf     = !(o == OP_BEQ || o == OP_SW);
        x.tgt    = (o == OP_LW) ? 2'b00 : (o == OP_JALR) ? 2'b10 : 2'b01;
        x.pc     = (o == OP_JALR) ? 2'b10 : (o == OP_BEQ && e) ? 2'b01 : 2'b00;
        case (o)
            OP_NAND:         x.func = 2'b01;
            OP_LUI, OP_JALR: x.func = 2'b10;
            OP_BEQ:          x.func = 2'b11;
            default:         x.func = 2'b00;
        endcase
        x.a1   = (o == OP_LUI);
        x.a2   = (o == OP_ADDI) || mem;
        x.mrf  = (o == OP_SW) || (o == OP_BEQ);
        x.rf_n = x.rf ? 1 : 0;
        x.dq_n = mem ? 1 + dw : 0;
        x.wd_n = (o == OP_SW) ? 1 + dw : 0;
        x.cnt  = 4'd0;
        return x;
    endfunction

    // Runs one instruction. iw/dw = ack delay in cycles (-1 = never).
    task automatic drive(input logic [2:0] o, input logic e, input logic h,
                         input int iw, input int dw, input logic run_after);
        int iwc = 0, dwc = 0, n = 0, cyc = 0, ir_n = 0, rf_n = 0, dq_n = 0, wd_n = 0;
        bit done = 0, have = 0;
        exp_t ex;
        a_fetch = 0; a_mem = 0; a_end = ST_IDLE;
        op = o; EQ = e; halt_hint = h;
        while (!done) begin
            @(negedge clk);
            run      = (state == ST_IDLE) ? 1'b1 : run_after;
            imem_ack = (state == ST_FETCH) && (iw >= 0) && (iwc >= iw);
            dmem_ack = (state == ST_MEM) && (dw >= 0) && (dwc >= dw);
            #1;
            if (state != ST_IDLE) cyc++;
            if (state == ST_FETCH) a_fetch++;
            if (state == ST_MEM) a_mem++;
            ir_n += int'(WE_ir);
            rf_n += int'(WE_rf);
            dq_n += int'(dmem_req);
            wd_n += int'(WE_dmem);
            if (WE_pc) begin
                done = 1;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_empty: unexpected retire op=%0d state=%0d", o, state);
                end else begin
                    ex = sb.pop_front();
                    have = 1;
                    if ({FUNC_alu, MUX_tgt, MUX_pc, WE_rf, MUX_alu1, MUX_alu2, MUX_rf} !==
                        {ex.func, ex.tgt, ex.pc, ex.rf, ex.a1, ex.a2, ex.mrf}) begin
                        errors++;
                        $display("FAIL retire_sel op=%0d: got func=%b tgt=%b pc=%b rf=%b a1=%b a2=%b mrf=%b want func=%b tgt=%b pc=%b rf=%b a1=%b a2=%b mrf=%b",
                                 o, FUNC_alu, MUX_tgt, MUX_pc, WE_rf, MUX_alu1, MUX_alu2, MUX_rf,
                                 ex.func, ex.tgt, ex.pc, ex.rf, ex.a1, ex.a2, ex.mrf);
                    end
                end
            end
            if (state == ST_HALT || state == ST_ERROR) begin a_end = state; done = 1; end
            if (state == ST_FETCH && !imem_ack) iwc++;
            if (state == ST_MEM && !dmem_ack) dwc++;
            n++;
            if (n > 100) begin
                checks++; errors++;
                $display("FAIL drive_bound: op=%0d stuck in state=%0d", o, state);
                done = 1;
            end
            @(posedge clk); #1;
        end
        imem_ack = 1'b0; dmem_ack = 1'b0;
        if (have) begin
            checks++;
            if (cyc != ex.cycles) begin
                errors++;
                $display("FAIL latency op=%0d: got %0d cycles want %0d", o, cyc, ex.cycles);
            end
            checks++;
            if ({ir_n, rf_n, dq_n, wd_n} != {32'(1), ex.rf_n, ex.dq_n, ex.wd_n}) begin
                errors++;
                $display("FAIL pulses op=%0d: got ir=%0d rf=%0d dreq=%0d wedm=%0d want ir=1 rf=%0d dreq=%0d wedm=%0d",
                         o, ir_n, rf_n, dq_n, wd_n, ex.rf_n, ex.dq_n, ex.wd_n);
            end
            checks++;
            if (instr_count !== ex.cnt) begin
                errors++;
                $display("FAIL instr_count op=%0d: got %0d want %0d", o, instr_count, ex.cnt);
            end
        end
    endtask

    // Queue the expectation of a retiring instruction, then run it.
    task automatic issue(input logic [2:0] o, input logic e, input int iw, input int dw, input logic run_after);
        exp_t x;
        x = model(o, e, iw, dw);
        exp_cnt = (exp_cnt + 1) % 16;
        x.cnt = 4'(exp_cnt);
        sb.push_back(x);
        drive(o, e, 1'b0, iw, dw, run_after);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        sb.delete();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
        checks++;
        if ({halted, err_timeout, instr_count} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got halted=%b err=%b cnt=%0d want 0 0 0", halted, err_timeout, instr_count);
        end
        checks++;
        if ({imem_req, dmem_req, WE_ir, WE_pc, WE_rf, WE_dmem, FUNC_alu, MUX_alu1, MUX_alu2, MUX_rf, MUX_pc, MUX_tgt}
            !== {6'b0, 2'b00, 3'b000, 2'b00, 2'b01}) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b%b we=%b%b%b%b func=%b mux=%b%b%b pc=%b tgt=%b want all 0, tgt=01",
                     imem_req, dmem_req, WE_ir, WE_pc, WE_rf, WE_dmem, FUNC_alu, MUX_alu1, MUX_alu2, MUX_rf, MUX_pc, MUX_tgt);
        end
    endtask

    task automatic test_alu();
        issue(OP_ADD, 1'b0, 0, 0, 1'b0);
        issue(OP_NAND, 1'b0, 0, 0, 1'b0);
        issue(OP_ADDI, 1'b0, 1, 0, 1'b0);
        issue(OP_LUI, 1'b0, 0, 0, 1'b0);
        issue(OP_JALR, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_lw_wait();
        issue(OP_LW, 1'b0, 0, 2, 1'b0);
    endtask

    task automatic test_sw();
        issue(OP_SW, 1'b0, 0, 1, 1'b0);
    endtask

    task automatic test_beq();
        issue(OP_BEQ, 1'b1, 0, 0, 1'b0);
        issue(OP_BEQ, 1'b0, 0, 0, 1'b0);
    endtask

    // An ack arriving on the last permitted wait cycle still completes.
    task automatic test_ack_boundary();
        issue(OP_ADD, 1'b0, 3, 0, 1'b0);
        issue(OP_LW, 1'b0, 0, 3, 1'b0);
        checks++;
        if (err_timeout !== 1'b0) begin errors++; $display("FAIL ack_boundary_err: got %b want 0", err_timeout); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] o;
        for (int i = 0; i < 8; i++) begin
            o = 3'($urandom_range(0, 7));
            issue(o, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2), (i != 7));
        end
    endtask

    task automatic test_halt();
        bit bad = 0;
        drive(OP_JALR, 1'b0, 1'b1, 0, 0, 1'b1);
        checks++;
        if (a_end !== ST_HALT) begin errors++; $display("FAIL halt_state: got %0d want 5", a_end); end
        checks++;
        if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag: got %b want 1", halted); end
        checks++;
        if (instr_count !== 4'(exp_cnt)) begin
            errors++; $display("FAIL halt_count: got %0d want %0d", instr_count, exp_cnt);
        end
        run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            if (state !== ST_HALT || WE_pc !== 1'b0 || halted !== 1'b1 || imem_req !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL halt_hold: state=%0d we_pc=%b halted=%b want 5 0 1", state, WE_pc, halted); end
        do_reset();
        #1;
        checks++;
        if (halted !== 1'b0) begin errors++; $display("FAIL halt_clear: got %b want 0", halted); end
    endtask

    task automatic test_timeout();
        bit bad = 0;
        drive(OP_ADD, 1'b0, 1'b0, -1, 0, 1'b1);
        checks++;
        if (a_end !== ST_ERROR || a_fetch != 4) begin
            errors++; $display("FAIL imem_timeout: got state=%0d fetch_cycles=%0d want 6 4", a_end, a_fetch);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            if (state !== ST_ERROR || err_timeout !== 1'b1 || imem_req !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL error_hold: state=%0d err=%b req=%b want 6 1 0", state, err_timeout, imem_req); end
        do_reset();
        #1;
        checks++;
        if ({err_timeout, state} !== 4'b0) begin
            errors++; $display("FAIL error_clear: got err=%b state=%0d want 0 0", err_timeout, state);
        end
        exp_cnt = 0;
        sb.push_back(model(OP_LW, 1'b0, 0, 0));
        sb.delete();
        drive(OP_LW, 1'b0, 1'b0, 0, -1, 1'b1);
        checks++;
        if (a_end !== ST_ERROR || a_mem != 4 || err_timeout !== 1'b1) begin
            errors++; $display("FAIL dmem_timeout: got state=%0d mem_cycles=%0d err=%b want 6 4 1", a_end, a_mem, err_timeout);
        end
        do_reset();
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 16; i++) begin
            issue(OP_ADD, 1'b0, 0, 0, (i != 15));
            if (i == 14) begin
                checks++;
                if (instr_count !== 4'd15) begin errors++; $display("FAIL count_15: got %0d want 15", instr_count); end
            end
        end
        checks++;
        if (instr_count !== 4'd0) begin errors++; $display("FAIL count_wrap: got %0d want 0", instr_count); end
    endtask

    task automatic test_mem_reset();
        int n = 0;
        issue(OP_ADD, 1'b0, 0, 0, 1'b0);
        op = OP_SW; EQ = 1'b0; halt_hint = 1'b0; run = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b0;
        while (state !== ST_MEM && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (state !== ST_MEM || {dmem_req, WE_dmem} !== 2'b11) begin
            errors++; $display("FAIL sw_mem_entry: got state=%0d dreq=%b wedm=%b want 4 1 1", state, dmem_req, WE_dmem);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({dmem_req, WE_dmem, WE_pc, WE_rf, WE_ir, imem_req} !== 6'b0) begin
            errors++; $display("FAIL mem_reset_outs: got dreq=%b wedm=%b we_pc=%b we_rf=%b we_ir=%b ireq=%b want 0",
                               dmem_req, WE_dmem, WE_pc, WE_rf, WE_ir, imem_req);
        end
        checks++;
        if ({state, halted, err_timeout, instr_count} !== 9'b0) begin
            errors++; $display("FAIL mem_reset_state: got state=%0d halted=%b err=%b cnt=%0d want 0",
                               state, halted, err_timeout, instr_count);
        end
        @(negedge clk);
        rst_n = 1'b1; run = 1'b0; imem_ack = 1'b0;
        exp_cnt = 0;
        sb.delete();
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; op = 3'd0; EQ = 1'b0; halt_hint = 1'b0;
        imem_ack = 1'b0; dmem_ack = 1'b0;
        test_reset();
        test_alu();
        test_lw_wait();
        test_sw();
        test_beq();
        test_ack_boundary();
        test_back_to_back();
        test_halt();
        test_timeout();
        test_wrap();
        test_mem_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
